// File: rtl/ddr_wr_arb_4ch.sv
// ddr_wr_arb_4ch: round-robin write arbiter granting one of four line buffers a full DDR burst at a time.
// Optional ARB_TIMEOUT_EN adds a grant-to-wdone watchdog that aborts a stalled burst.
module ddr_wr_arb_4ch #(
  parameter int ADDR_WIDTH  = 27,
  parameter int DQ_WIDTH    = 16,
  parameter int LEN_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      ddr_clk,
  input  logic                      ddr_rstn,
  input  logic [3:0]                ch_wreq,
  input  logic [4*ADDR_WIDTH-1:0]   ch_waddr,
  input  logic [4*LEN_WIDTH-1:0]    ch_wr_len,
  input  logic [4*8*DQ_WIDTH-1:0]   ch_wdata,
  output logic [3:0]                ch_wrdy,
  output logic [3:0]                ch_wdata_req,
  output logic [3:0]                ch_wdone,
  output logic                      ddr_wreq,
  output logic [ADDR_WIDTH-1:0]     ddr_waddr,
  output logic [LEN_WIDTH-1:0]      ddr_wr_len,
  input  logic                      ddr_wrdy,
  input  logic                      ddr_wdata_req,
  input  logic                      ddr_wdone,
  output logic [8*DQ_WIDTH-1:0]     ddr_wdata,
  output logic [1:0]                gnt_id,
  output logic                      arb_busy,
  output logic                      timeout_err
);
  localparam int DW = 8 * DQ_WIDTH;
  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  state_t state, state_nx;
  logic [1:0] rr_ptr, off, pick;
  logic [7:0] req2;
  logic [3:0] rot;
  logic grant, abort;
  // Rotate requests so the search always starts at bit 0 = rr_ptr
  assign req2  = {ch_wreq, ch_wreq};
  assign rot   = req2[rr_ptr +: 4];
  assign off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign pick  = rr_ptr + off;
  assign grant = (state == IDLE) && (|ch_wreq);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (|ch_wreq) ? REQ : IDLE;
      REQ:     state_nx = ddr_wdata_req ? DATA : REQ;
      DATA:    state_nx = ddr_wdone ? IDLE : DATA;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end
  always_ff @(posedge ddr_clk or negedge ddr_rstn)
    if (!ddr_rstn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_id     <= '0;
      ddr_wreq   <= 1'b0;
      ddr_waddr  <= '0;
      ddr_wr_len <= '0;
    end else begin
      state    <= state_nx;
      ddr_wreq <= (state_nx == REQ);
      if (state != IDLE && state_nx == IDLE) rr_ptr <= gnt_id + 2'd1;
      if (grant) begin
        gnt_id     <= pick;
        ddr_waddr  <= ch_waddr[ADDR_WIDTH*int'(pick) +: ADDR_WIDTH];
        ddr_wr_len <= ch_wr_len[LEN_WIDTH*int'(pick) +: LEN_WIDTH];
      end
    end
  // Controller handshakes reach only the granted buffer, with zero latency
  always_comb begin
    ch_wrdy              = '0;
    ch_wdata_req         = '0;
    ch_wdone             = '0;
    ch_wrdy[gnt_id]      = ddr_wrdy & (state != IDLE);
    ch_wdata_req[gnt_id] = ddr_wdata_req & (state != IDLE);
    ch_wdone[gnt_id]     = ddr_wdone & (state == DATA);
  end
  assign ddr_wdata = ch_wdata[DW*int'(gnt_id) +: DW];
  assign arb_busy  = (state != IDLE);
`ifdef ARB_TIMEOUT_EN
  logic [15:0] tcnt;
  assign abort = (state != IDLE) && (tcnt == 16'(TIMEOUT_CYC - 1)) && !((state == DATA) && ddr_wdone);
  always_ff @(posedge ddr_clk or negedge ddr_rstn)
    if (!ddr_rstn) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt        <= grant ? '0 : (state != IDLE) ? tcnt + 16'd1 : tcnt;
      timeout_err <= abort;
    end
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_ddr_wr_arb_4ch.sv
// tb_ddr_wr_arb_4ch: self-checking bench for ddr_wr_arb_4ch with a round-robin reference model.
module tb_ddr_wr_arb_4ch;
  localparam int AW = 27, DQ = 16, LW = 16, DW = 8 * DQ, TCYC = 256;
  logic ddr_clk = 1'b0, ddr_rstn = 1'b0;
  logic [3:0] ch_wreq = '0;
  logic [4*AW-1:0] ch_waddr = '0;
  logic [4*LW-1:0] ch_wr_len = '0;
  logic [4*DW-1:0] ch_wdata = '0;
  logic [3:0] ch_wrdy, ch_wdata_req, ch_wdone;
  logic ddr_wreq, arb_busy, timeout_err;
  logic [AW-1:0] ddr_waddr;
  logic [LW-1:0] ddr_wr_len;
  logic ddr_wrdy = 1'b0, ddr_wdata_req = 1'b0, ddr_wdone = 1'b0;
  logic [DW-1:0] ddr_wdata;
  logic [1:0] gnt_id;
  int errors = 0, checks = 0, m_rr = 0;
  always #5 ddr_clk = ~ddr_clk;
  ddr_wr_arb_4ch #(.ADDR_WIDTH(AW), .DQ_WIDTH(DQ), .LEN_WIDTH(LW), .TIMEOUT_CYC(TCYC)) dut (
    .ddr_clk(ddr_clk), .ddr_rstn(ddr_rstn), .ch_wreq(ch_wreq), .ch_waddr(ch_waddr),
    .ch_wr_len(ch_wr_len), .ch_wdata(ch_wdata), .ch_wrdy(ch_wrdy), .ch_wdata_req(ch_wdata_req),
    .ch_wdone(ch_wdone), .ddr_wreq(ddr_wreq), .ddr_waddr(ddr_waddr), .ddr_wr_len(ddr_wr_len),
    .ddr_wrdy(ddr_wrdy), .ddr_wdata_req(ddr_wdata_req), .ddr_wdone(ddr_wdone), .ddr_wdata(ddr_wdata),
    .gnt_id(gnt_id), .arb_busy(arb_busy), .timeout_err(timeout_err));

  task automatic tick;
    @(posedge ddr_clk);
    #1;
  endtask

  function automatic int exp_pick(input logic [3:0] m, input int rr);
    for (int k = 0; k < 4; k++) if (m[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  task automatic do_reset;
    ddr_rstn = 1'b0; ch_wreq = '0; ddr_wdata_req = 0; ddr_wdone = 0; ddr_wrdy = 0;
    tick; tick;
    ddr_rstn = 1'b1;
    m_rr = 0;
  endtask

  // Acts as the controller for a granted burst (entered in REQ) and tallies what each channel sees
  task automatic serve(input int g, input int n, output int own, output int other,
                       output int wd_own, output int wd_other, output int dmis);
    logic [3:0] mask;
    mask = ~(4'b0001 << g);
    own = 0; other = 0; wd_own = 0; wd_other = 0; dmis = 0;
    for (int i = 0; i < n; i++) begin
      ddr_wdata_req = 1'b1; ddr_wrdy = 1'b1;
      ch_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      #1;
      own += int'(ch_wdata_req[g] & ch_wrdy[g]);
      other += $countones(ch_wdata_req & mask) + $countones(ch_wrdy & mask);
      wd_other += $countones(ch_wdone);
      if (ddr_wdata !== ch_wdata[g*DW +: DW]) dmis++;
      tick;
      ddr_wdata_req = 1'b0; ddr_wrdy = 1'b0;
    end
    repeat ($urandom_range(0, 2)) tick;
    ddr_wdone = 1'b1;
    #1;
    wd_own = int'(ch_wdone[g]);
    wd_other += $countones(ch_wdone & mask);
    tick;
    ddr_wdone = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (ddr_wreq !== 1'b0) begin errors++; $display("FAIL reset_wreq got=%0b exp=0", ddr_wreq); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt got=%0d exp=0", gnt_id); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", arb_busy); end
    checks++; if ({ddr_waddr, ddr_wr_len} !== '0) begin errors++; $display("FAIL reset_addr_len got=%h/%h exp=0", ddr_waddr, ddr_wr_len); end
    checks++; if ({ch_wrdy, ch_wdata_req, ch_wdone, timeout_err} !== '0) begin errors++; $display("FAIL reset_ch got=%h exp=0", {ch_wrdy, ch_wdata_req, ch_wdone, timeout_err}); end
  endtask

  task automatic test_single;
    int own, other, wo, wx, dm;
    ch_waddr[2*AW +: AW] = 27'h0001400; ch_wr_len[2*LW +: LW] = 16'd160; ch_wreq = 4'b0100;
    tick;
    checks++; if (ddr_wreq !== 1'b1) begin errors++; $display("FAIL single_wreq got=%0b exp=1", ddr_wreq); end
    checks++; if (gnt_id !== 2'd2) begin errors++; $display("FAIL single_gnt got=%0d exp=2", gnt_id); end
    checks++; if (ddr_waddr !== 27'h0001400) begin errors++; $display("FAIL single_addr got=%h exp=0001400", ddr_waddr); end
    checks++; if (ddr_wr_len !== 16'd160) begin errors++; $display("FAIL single_len got=%0d exp=160", ddr_wr_len); end
    serve(2, 160, own, other, wo, wx, dm);
    ch_wreq = '0;
    checks++; if (own !== 160 || other !== 0) begin errors++; $display("FAIL single_route got=%0d/%0d exp=160/0", own, other); end
    checks++; if (wo !== 1 || wx !== 0) begin errors++; $display("FAIL single_wdone got=%0d/%0d exp=1/0", wo, wx); end
    checks++; if (dm !== 0) begin errors++; $display("FAIL single_wdata got=%0d exp=0 mismatches", dm); end
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%0b exp=0", arb_busy); end
    m_rr = 3;
  endtask

  task automatic test_rr_all;
    int own, other, wo, wx, dm, e;
    do_reset;
    for (int c = 0; c < 4; c++) ch_waddr[c*AW +: AW] = 27'(c * 256 + 5);
    ch_wreq = 4'hF;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      tick;
      checks++; if (ddr_wreq !== 1'b1 || gnt_id !== 2'(e)) begin errors++; $display("FAIL rr_gnt k=%0d got=%0d/%0b exp=%0d/1", k, gnt_id, ddr_wreq, e); end
      checks++; if (ddr_waddr !== 27'(e * 256 + 5)) begin errors++; $display("FAIL rr_addr k=%0d got=%h exp=%h", k, ddr_waddr, e * 256 + 5); end
      serve(e, 2, own, other, wo, wx, dm);
      checks++; if (own !== 2 || other !== 0 || wo !== 1 || wx !== 0) begin errors++; $display("FAIL rr_route k=%0d got=%0d/%0d/%0d/%0d exp=2/0/1/0", k, own, other, wo, wx); end
      checks++; if (arb_busy !== 1'b0 || ddr_wreq !== 1'b0) begin errors++; $display("FAIL rr_idle_gap k=%0d got=%0b/%0b exp=0/0", k, arb_busy, ddr_wreq); end
    end
    ch_wreq = '0;
    m_rr = 1;
  endtask

  task automatic test_overlap;
    int own, other, wo, wx, dm;
    ch_waddr[1*AW +: AW] = 27'h0000AAA; ch_waddr[3*AW +: AW] = 27'h0003333; ch_wreq = 4'b0010;
    tick;
    checks++; if (gnt_id !== 2'd1) begin errors++; $display("FAIL ovl_gnt1 got=%0d exp=1", gnt_id); end
    ddr_wdata_req = 1'b1; tick; ddr_wdata_req = 1'b0;
    ch_wreq = 4'b1000; ch_waddr[1*AW +: AW] = 27'h0005555;
    tick;
    checks++; if (ddr_waddr !== 27'h0000AAA || gnt_id !== 2'd1 || ddr_wreq !== 1'b0) begin errors++; $display("FAIL ovl_hold got=%h/%0d/%0b exp=0000aaa/1/0", ddr_waddr, gnt_id, ddr_wreq); end
    ddr_wdone = 1'b1; #1;
    checks++; if (ch_wdone !== 4'b0010) begin errors++; $display("FAIL ovl_wdone got=%b exp=0010", ch_wdone); end
    tick; ddr_wdone = 1'b0;
    tick;
    checks++; if (gnt_id !== 2'd3 || ddr_waddr !== 27'h0003333) begin errors++; $display("FAIL ovl_gnt3 got=%0d/%h exp=3/0003333", gnt_id, ddr_waddr); end
    ch_wreq = '0;
    serve(3, 1, own, other, wo, wx, dm);
    checks++; if (wo !== 1 || other !== 0) begin errors++; $display("FAIL ovl_done3 got=%0d/%0d exp=1/0", wo, other); end
    m_rr = 0;
  endtask

  task automatic test_collide;
    ddr_wdone = 1'b1; #1;
    checks++; if (ch_wdone !== 4'b0000) begin errors++; $display("FAIL col_idle_wdone got=%b exp=0000", ch_wdone); end
    tick; ddr_wdone = 1'b0;
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL col_idle_busy got=%0b exp=0", arb_busy); end
    ch_wreq = 4'b0001;
    tick; ch_wreq = '0;
    ddr_wdone = 1'b1; #1;
    checks++; if (ch_wdone !== 4'b0000) begin errors++; $display("FAIL col_req_wdone got=%b exp=0000", ch_wdone); end
    tick;
    checks++; if (ddr_wreq !== 1'b1) begin errors++; $display("FAIL col_req_hold got=%0b exp=1", ddr_wreq); end
    ddr_wdata_req = 1'b1; #1;
    checks++; if (ch_wdone !== 4'b0000 || ch_wdata_req !== 4'b0001) begin errors++; $display("FAIL col_both got=%b/%b exp=0000/0001", ch_wdone, ch_wdata_req); end
    tick; ddr_wdata_req = 1'b0; ddr_wdone = 1'b0;
    checks++; if (arb_busy !== 1'b1 || ddr_wreq !== 1'b0) begin errors++; $display("FAIL col_data got=%0b/%0b exp=1/0", arb_busy, ddr_wreq); end
    tick;
    ddr_wdone = 1'b1; #1;
    checks++; if (ch_wdone !== 4'b0001) begin errors++; $display("FAIL col_final got=%b exp=0001", ch_wdone); end
    tick; ddr_wdone = 1'b0;
    checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL col_end got=%0b exp=0", arb_busy); end
    m_rr = 1;
  endtask

  task automatic test_random;
    int own, other, wo, wx, dm, g, n;
    logic [3:0] mask;
    logic [AW-1:0] ea;
    logic [LW-1:0] el;
    for (int it = 0; it < 25; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) begin
        ch_waddr[c*AW +: AW] = 27'($urandom);
        ch_wr_len[c*LW +: LW] = 16'($urandom);
      end
      ch_wreq = mask;
      g = exp_pick(mask, m_rr);
      ea = ch_waddr[g*AW +: AW]; el = ch_wr_len[g*LW +: LW];
      tick;
      checks++; if (gnt_id !== 2'(g) || ddr_wreq !== 1'b1) begin errors++; $display("FAIL rnd_gnt it=%0d got=%0d/%0b exp=%0d/1", it, gnt_id, ddr_wreq, g); end
      checks++; if (ddr_waddr !== ea || ddr_wr_len !== el) begin errors++; $display("FAIL rnd_latch it=%0d got=%h/%h exp=%h/%h", it, ddr_waddr, ddr_wr_len, ea, el); end
      ch_waddr = {$urandom, $urandom, $urandom, $urandom}; ch_wreq = 4'($urandom);
      n = $urandom_range(1, 5);
      serve(g, n, own, other, wo, wx, dm);
      checks++; if (own !== n || other !== 0 || wo !== 1 || wx !== 0 || dm !== 0) begin errors++; $display("FAIL rnd_route it=%0d got=%0d/%0d/%0d/%0d/%0d exp=%0d/0/1/0/0", it, own, other, wo, wx, dm, n); end
      checks++; if (ddr_waddr !== ea) begin errors++; $display("FAIL rnd_stable it=%0d got=%h exp=%h", it, ddr_waddr, ea); end
      m_rr = (g + 1) % 4;
    end
    ch_wreq = '0;
  endtask

  task automatic test_reset_mid;
    int own, other, wo, wx, dm;
    ch_wreq = 4'b0100;
    tick; ch_wreq = '0;
    ddr_wdata_req = 1'b1; tick; ddr_wdata_req = 1'b0;
    ddr_wdone = 1'b1; #2;
    ddr_rstn = 1'b0; #1;
    checks++; if (ch_wdone !== 4'b0000 || ddr_wreq !== 1'b0 || arb_busy !== 1'b0) begin errors++; $display("FAIL rstmid_out got=%b/%0b/%0b exp=0000/0/0", ch_wdone, ddr_wreq, arb_busy); end
    checks++; if (gnt_id !== 2'd0 || ddr_waddr !== '0 || ddr_wr_len !== '0) begin errors++; $display("FAIL rstmid_regs got=%0d/%h/%h exp=0/0/0", gnt_id, ddr_waddr, ddr_wr_len); end
    ddr_wdone = 1'b0; ch_wreq = 4'hF;
    tick;
    ddr_rstn = 1'b1; m_rr = 0;
    tick;
    checks++; if (gnt_id !== 2'd0 || ddr_wreq !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got=%0d/%0b exp=0/1", gnt_id, ddr_wreq); end
    ch_wreq = '0;
    serve(0, 1, own, other, wo, wx, dm);
    m_rr = 1;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    int own, other, wo, wx, dm;
    ch_wreq = 4'b0110;
    tick;
    checks++; if (gnt_id !== 2'd1) begin errors++; $display("FAIL to_gnt got=%0d exp=1", gnt_id); end
    repeat (TCYC - 1) tick;
    checks++; if (timeout_err !== 1'b0 || arb_busy !== 1'b1) begin errors++; $display("FAIL to_early got=%0b/%0b exp=0/1", timeout_err, arb_busy); end
    tick;
    checks++; if (timeout_err !== 1'b1 || arb_busy !== 1'b0 || ch_wdone !== 4'b0000) begin errors++; $display("FAIL to_pulse got=%0b/%0b/%b exp=1/0/0000", timeout_err, arb_busy, ch_wdone); end
    tick;
    checks++; if (timeout_err !== 1'b0 || gnt_id !== 2'd2 || ddr_wreq !== 1'b1) begin errors++; $display("FAIL to_next got=%0b/%0d/%0b exp=0/2/1", timeout_err, gnt_id, ddr_wreq); end
    ch_wreq = '0;
    serve(2, 1, own, other, wo, wx, dm);
  endtask
`endif

  initial begin
    do_reset;
    test_reset;
    test_single;
    test_rr_all;
    test_overlap;
    test_collide;
    test_random;
    test_reset_mid;
`ifdef ARB_TIMEOUT_EN
    test_timeout;
`else
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_tied got=%0b exp=0", timeout_err); end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
